obj_vel_integrator: RTL and testbench

//  Per-step sequencer ahead of the position-integration stage. On a step pulse it walks object slots
//  0..NUM_OBJ-1, reads each dynamic record {pos_x,pos_y,vel_x,vel_y} from object RAM and adds gravity to vel_y.

---
 rtl/obj_vel_integrator_pkg.sv | 35 +++
 rtl/obj_vel_integrator_if.sv | 28 ++
 rtl/obj_vel_integrator_phys_vel_add.sv | 21 ++
 rtl/obj_vel_integrator.sv | 124 ++++++++++++
 tb/tb_obj_vel_integrator.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/obj_vel_integrator_pkg.sv
// rtl/obj_vel_integrator_pkg.sv - shared fixed-point defines, record slicing and clamp helpers, FSM states
`ifndef SF
`define SF 16
`endif
`ifndef DF_DEC
`define DF_DEC 8
`endif
`ifndef OBJ_DYN_WIDTH
`define OBJ_DYN_WIDTH (4*`SF)
`endif

package obj_vel_integrator_pkg;
  localparam int SF_W  = `SF;
  localparam int DT_W  = `DF_DEC + 2;
  localparam int REC_W = `OBJ_DYN_WIDTH;
  localparam int SUM_W = SF_W + 3;

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WAIT, ST_CALC, ST_OUT, ST_FIN} state_e;

  // Record layout is {pos_x, pos_y, vel_x, vel_y}, vel_y in the low bits.
  typedef enum int unsigned {F_VEL_Y = 0, F_VEL_X = 1, F_POS_Y = 2, F_POS_X = 3} field_e;

  function automatic logic [SF_W-1:0] rec_field(input logic [REC_W-1:0] rec, input field_e f);
    return rec[int'(f)*SF_W +: SF_W];
  endfunction

  function automatic logic [SF_W-1:0] vel_clamp(input logic signed [SUM_W-1:0] v,
                                                input logic [SF_W-1:0] vmax);
    logic signed [SUM_W-1:0] lim;
    lim = $signed(SUM_W'(vmax));
    if (v > lim) return vmax;
    if (v < -lim) return -vmax;
    return v[SF_W-1:0];
  endfunction
endpackage

// File: rtl/obj_vel_integrator_if.sv
// rtl/obj_vel_integrator_if.sv - step control, object RAM read port and downstream record handshake
interface obj_vel_integrator_if
  import obj_vel_integrator_pkg::*;
#(
  parameter int ADDR_W = 3
);
  logic                    step_start_in;
  logic signed [DT_W-1:0]  time_step_in;
  logic                    obj_rd_en_out;
  logic [ADDR_W-1:0]       obj_addr_out;
  logic [REC_W-1:0]        obj_dyn_rd_in;
  logic [REC_W-1:0]        obj_dyn_out;
  logic [ADDR_W-1:0]       obj_id_out;
  logic                    obj_valid_out;
  logic                    obj_ready_in;
  logic                    busy_out;
  logic                    done_out;

  modport slave (
    input  step_start_in, time_step_in, obj_dyn_rd_in, obj_ready_in,
    output obj_rd_en_out, obj_addr_out, obj_dyn_out, obj_id_out, obj_valid_out, busy_out, done_out
  );

  modport master (
    output step_start_in, time_step_in, obj_dyn_rd_in, obj_ready_in,
    input  obj_rd_en_out, obj_addr_out, obj_dyn_out, obj_id_out, obj_valid_out, busy_out, done_out
  );
endinterface

// File: rtl/obj_vel_integrator_phys_vel_add.sv
// rtl/obj_vel_integrator_phys_vel_add.sv - combinational vel_y' = vel_y + (GRAVITY*dt >>> DF_DEC), optional clamp
module phys_vel_add
  import obj_vel_integrator_pkg::*;
#(
  parameter int              GRAVITY  = -16,
  parameter logic [SF_W-1:0] VEL_MAX  = 16'h3FFF,
  parameter bit              CLAMP_EN = 1'b0
) (
  input  logic signed [SF_W-1:0] vel_y_i,
  input  logic signed [DT_W-1:0] dt_i,
  output logic        [SF_W-1:0] vel_y_o
);
  localparam int PROD_W = SF_W + DT_W;
  localparam logic signed [SF_W-1:0] GRAV = SF_W'(GRAVITY);

  // Sum is kept wide so the clamp sees the true value before any wrap.
  logic signed [SUM_W-1:0] sum;

  assign sum = SUM_W'(vel_y_i) + SUM_W'((PROD_W'(GRAV) * PROD_W'(dt_i)) >>> `DF_DEC);
  assign vel_y_o = CLAMP_EN ? vel_clamp(sum, VEL_MAX) : sum[SF_W-1:0];
endmodule

// File: rtl/obj_vel_integrator.sv
// rtl/obj_vel_integrator.sv - per-step object walker adding gravity to vel_y; PHYS_VEL_CLAMP_EN enables velocity clamp
module obj_vel_integrator
  import obj_vel_integrator_pkg::*;
#(
  parameter int              NUM_OBJ = 8,
  parameter int              ADDR_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
  parameter int              RAM_LAT = 2,
  parameter int              GRAVITY = -16,
  parameter logic [SF_W-1:0] VEL_MAX = 16'h3FFF
) (
  input  logic clk_in,
  input  logic rst_in,
  obj_vel_integrator_if.slave bus
);
`ifdef PHYS_VEL_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif
  localparam int                CNT_W    = $clog2(RAM_LAT + 1);
  localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(RAM_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NUM_OBJ - 1);

  state_e                  state_q;
  logic [ADDR_W-1:0]       idx_q;
  logic signed [DT_W-1:0]  dt_q;
  logic [CNT_W-1:0]        lat_cnt_q;
  logic [REC_W-1:0]        rec_q;
  logic [REC_W-1:0]        out_q;
  logic                    rd_en_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic [SF_W-1:0]         vel_y_d;
  logic [SF_W-1:0]         vel_x_d;
  logic [REC_W-1:0]        out_d;

  phys_vel_add #(
    .GRAVITY  (GRAVITY),
    .VEL_MAX  (VEL_MAX),
    .CLAMP_EN (CLAMP_EN)
  ) u_vel_add (
    .vel_y_i (rec_field(rec_q, F_VEL_Y)),
    .dt_i    (dt_q),
    .vel_y_o (vel_y_d)
  );

  assign vel_x_d = CLAMP_EN ? vel_clamp(SUM_W'($signed(rec_field(rec_q, F_VEL_X))), VEL_MAX)
                            : rec_field(rec_q, F_VEL_X);
  assign out_d = {rec_field(rec_q, F_POS_X), rec_field(rec_q, F_POS_Y), vel_x_d, vel_y_d};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      dt_q      <= '0;
      lat_cnt_q <= '0;
      rec_q     <= '0;
      out_q     <= '0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.step_start_in) begin
            dt_q    <= bus.time_step_in;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            state_q <= ST_RD;
          end
        end
        ST_RD: begin
          rd_en_q   <= 1'b0;
          lat_cnt_q <= '0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt_q == LAT_LAST) begin
            rec_q   <= bus.obj_dyn_rd_in;
            state_q <= ST_CALC;
          end else begin
            lat_cnt_q <= lat_cnt_q + CNT_W'(1);
          end
        end
        ST_CALC: begin
          out_q   <= out_d;
          valid_q <= 1'b1;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          // Record and id stay registered and untouched until the handshake.
          if (bus.obj_ready_in) begin
            valid_q <= 1'b0;
            if (idx_q == LAST) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_FIN;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              rd_en_q <= 1'b1;
              state_q <= ST_RD;
            end
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.obj_rd_en_out = rd_en_q;
  assign bus.obj_addr_out  = idx_q;
  assign bus.obj_dyn_out   = out_q;
  assign bus.obj_id_out    = idx_q;
  assign bus.obj_valid_out = valid_q;
  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;
endmodule

// File: tb/tb_obj_vel_integrator.sv
// tb/tb_obj_vel_integrator.sv - randomized bench for obj_vel_integrator against a behavioural step model
module tb_obj_vel_integrator;
  import obj_vel_integrator_pkg::*;

  localparam int NUM_OBJ = 4;
  localparam int RAM_LAT = 2;
  localparam int GRAV    = -16;
  localparam int VMAX    = 16'h3FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  obj_vel_integrator_if #(.ADDR_W(2)) bus ();

  obj_vel_integrator #(
    .NUM_OBJ (NUM_OBJ),
    .ADDR_W  (2),
    .RAM_LAT (RAM_LAT),
    .GRAVITY (GRAV),
    .VEL_MAX (16'h3FFF)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [NUM_OBJ];
  logic [63:0] ram_p1;

  // Two-stage read pipe: data appears RAM_LAT cycles after rd_en, poison otherwise.
  always @(posedge clk) begin
    ram_p1 <= bus.obj_rd_en_out ? mem[bus.obj_addr_out] : 64'hDEAD_BEEF_DEAD_BEEF;
    bus.obj_dyn_rd_in <= ram_p1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] r, input int dt);
    int vy, vx, nv;
    vy = int'($signed(r[15:0]));
    vx = int'($signed(r[31:16]));
    nv = vy + ((GRAV * dt) >>> 8);
`ifdef PHYS_VEL_CLAMP_EN
    if (nv > VMAX) nv = VMAX;
    if (nv < -VMAX) nv = -VMAX;
    if (vx > VMAX) vx = VMAX;
    if (vx < -VMAX) vx = -VMAX;
`endif
    return {r[63:32], 16'(vx), 16'(nv)};
  endfunction

  int          cyc = 0;
  int          acc_id[$];
  logic [63:0] acc_dat[$];
  int          acc_cyc[$];
  int          rd_cyc[$];
  int          done_cnt, done_cyc, stall_cnt;
  bit          hold_prev = 1'b0;
  logic [63:0] hold_dat;
  int          hold_id;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(bus.obj_valid_out), 64'd1);
        chk("hold_data", bus.obj_dyn_out, hold_dat);
        chk("hold_id", 64'(bus.obj_id_out), 64'(hold_id));
        chk("hold_no_rd", 64'(bus.obj_rd_en_out), 64'd0);
      end
      if (bus.obj_rd_en_out) rd_cyc.push_back(cyc);
      if (bus.obj_valid_out && bus.obj_ready_in) begin
        acc_id.push_back(int'(bus.obj_id_out));
        acc_dat.push_back(bus.obj_dyn_out);
        acc_cyc.push_back(cyc);
      end
      if (bus.obj_valid_out && !bus.obj_ready_in) stall_cnt++;
      if (bus.done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
      hold_prev = bus.obj_valid_out && !bus.obj_ready_in;
      hold_dat  = bus.obj_dyn_out;
      hold_id   = int'(bus.obj_id_out);
    end
  end

  int rdy_mode = 0;
  int stall_left = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.obj_ready_in = 1'b1;
      1: begin
        if (bus.obj_valid_out && bus.obj_id_out == 2'd1 && stall_left > 0) begin
          bus.obj_ready_in = 1'b0;
          stall_left--;
        end else begin
          bus.obj_ready_in = 1'b1;
        end
      end
      2: bus.obj_ready_in = 1'($urandom_range(0, 1));
      default: bus.obj_ready_in = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < NUM_OBJ; i++) mem[i] = {$urandom, $urandom};
  endtask

  function automatic int rand_dt();
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  task automatic run_step(input int dt, input int mode, input bit mid, input string tg);
    bit seen;
    acc_id.delete();
    acc_dat.delete();
    acc_cyc.delete();
    rd_cyc.delete();
    done_cnt = 0;
    stall_cnt = 0;
    stall_left = 10;
    rdy_mode = mode;
    tick();
    bus.time_step_in = DT_W'(dt);
    bus.step_start_in = 1'b1;
    tick();
    bus.step_start_in = 1'b0;
    bus.time_step_in = DT_W'(rand_dt());
    if (mid) begin
      repeat (7) tick();
      bus.step_start_in = 1'b1;
      tick();
      bus.step_start_in = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done_out;
    end
    chk($sformatf("%s_done_seen", tg), 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    chk($sformatf("%s_n_out", tg), 64'(acc_id.size()), 64'(NUM_OBJ));
    chk($sformatf("%s_n_done", tg), 64'(done_cnt), 64'd1);
    chk($sformatf("%s_busy_after", tg), 64'(bus.busy_out), 64'd0);
    for (int i = 0; i < acc_id.size(); i++) begin
      chk($sformatf("%s_id%0d", tg, i), 64'(acc_id[i]), 64'(i));
      if (i < NUM_OBJ) chk($sformatf("%s_rec%0d", tg, i), acc_dat[i], model(mem[i], dt));
    end
    if (acc_cyc.size() > 0)
      chk($sformatf("%s_done_lat", tg), 64'(done_cyc - acc_cyc[acc_cyc.size()-1]), 64'd1);
    if (mode == 0) begin
      chk($sformatf("%s_n_rd", tg), 64'(rd_cyc.size()), 64'(NUM_OBJ));
      if (rd_cyc.size() == NUM_OBJ && acc_cyc.size() == NUM_OBJ) begin
        chk($sformatf("%s_lat0", tg), 64'(acc_cyc[0] - rd_cyc[0]), 64'd4);
        for (int i = 1; i < NUM_OBJ; i++)
          chk($sformatf("%s_rd_gap%0d", tg, i), 64'(rd_cyc[i] - rd_cyc[i-1]), 64'd5);
      end
    end
    if (mode == 1) chk($sformatf("%s_stall", tg), 64'(stall_cnt), 64'd10);
  endtask

  initial begin
    bit seen;
    logic [15:0] exp_sat;
    bus.step_start_in = 1'b0;
    bus.time_step_in = '0;
    bus.obj_ready_in = 1'b0;
    load_mem();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.obj_valid_out), 64'd0);
    chk("rst_busy", 64'(bus.busy_out), 64'd0);
    chk("rst_done", 64'(bus.done_out), 64'd0);
    chk("rst_rd_en", 64'(bus.obj_rd_en_out), 64'd0);
    chk("rst_addr", 64'(bus.obj_addr_out), 64'd0);
    chk("rst_id", 64'(bus.obj_id_out), 64'd0);
    chk("rst_dyn", bus.obj_dyn_out, 64'd0);
    rst = 1'b0;

    mem[0][15:0] = 16'd100;
    run_step(256, 0, 1'b0, "t1");
    if (acc_dat.size() > 0) chk("t1_vel_y_84", 64'(acc_dat[0][15:0]), 64'd84);

    load_mem();
    run_step(rand_dt(), 1, 1'b0, "t3_stall");

    load_mem();
    mem[2][15:0] = 16'h7FF8;
    mem[3][31:16] = 16'h8000;
    run_step(-256, 0, 1'b0, "t4_edge");
`ifdef PHYS_VEL_CLAMP_EN
    exp_sat = 16'h3FFF;
`else
    exp_sat = 16'h8008;
`endif
    if (acc_dat.size() > 2) chk("t4_vel_y_edge", 64'(acc_dat[2][15:0]), 64'(exp_sat));

    load_mem();
    run_step(0, 2, 1'b0, "dt0");

    load_mem();
    run_step(rand_dt(), 0, 1'b1, "t5_restart");

    for (int k = 0; k < 4; k++) begin
      load_mem();
      run_step(rand_dt(), 2, 1'b0, $sformatf("rnd%0d", k));
    end

    rdy_mode = 3;
    tick();
    bus.time_step_in = DT_W'(rand_dt());
    bus.step_start_in = 1'b1;
    tick();
    bus.step_start_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.obj_valid_out;
    end
    chk("t6_valid_before_rst", 64'(seen), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.obj_valid_out), 64'd0);
    chk("t6_rst_busy", 64'(bus.busy_out), 64'd0);
    chk("t6_rst_done", 64'(bus.done_out), 64'd0);
    tick();
    rst = 1'b0;
    load_mem();
    run_step(rand_dt(), 0, 1'b0, "t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
